// File: rtl/rdma_ack_pacer_if.sv
// AXI4-Stream bundle shared by the ingress FIFO, the pacer and the RDMA stack.
// The master modport drives the payload and valid; the slave modport drives ready.
interface AXI4S #(
    parameter int DATA_W = 256
) ();
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport m (output tdata, tkeep, tlast, tvalid, input tready);
    modport s (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/rdma_ack_pacer.sv
// rdma_ack_pacer: classifies packets on their first beat and, after the last beat of a
// matching packet, holds off the next packet start for cfg_gap cycles. No buffering.
module rdma_ack_pacer #(
    parameter logic [15:0] HDR_MATCH = 16'h0245,
    parameter int          OPC_LSB   = 224,
    parameter logic [7:0]  ACK_OPC   = 8'h11,
    parameter int          CNT_W     = 16
) (
    input  logic             nclk,
    input  logic             nresetn,
    AXI4S.s                  input_stream,
    AXI4S.m                  output_stream,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic             stats_clear,
    output logic             gap_active,
    output logic [31:0]      match_count,
    output logic [31:0]      stall_count
);
    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'b00,
        MODE_ACK     = 2'b01,
        MODE_ROCE    = 2'b10,
        MODE_ACK_ALT = 2'b11
    } mode_e;

    mode_e            w_mode;
    logic             w_gate;
    logic             w_accept;
    logic             w_last_acc;
    logic             w_roce;
    logic             w_ack;
    logic             w_match;
    logic             w_eff_match;
    logic             w_load;
    logic [CNT_W-1:0] w_gap_nxt;

    logic             r_sop;
    logic             r_pkt_match;
    logic             r_gap_active;
    logic [CNT_W-1:0] r_gap_cnt;
    logic [31:0]      r_match_count;
    logic [31:0]      r_stall_count;

    assign w_mode = mode_e'(cfg_mode);

    // Only packet starts are gated, so a running gap can never split a packet.
    assign w_gate = r_sop & (r_gap_cnt != '0);

    assign output_stream.tdata  = input_stream.tdata;
    assign output_stream.tkeep  = input_stream.tkeep;
    assign output_stream.tlast  = input_stream.tlast;
    assign output_stream.tvalid = input_stream.tvalid & ~w_gate;
    assign input_stream.tready  = output_stream.tready & ~w_gate;

    assign w_accept   = input_stream.tvalid & output_stream.tready & ~w_gate;
    assign w_last_acc = w_accept & input_stream.tlast;

    assign w_roce = (input_stream.tdata[15:0] == HDR_MATCH);
    assign w_ack  = w_roce & (input_stream.tdata[OPC_LSB +: 8] == ACK_OPC);

    always_comb begin
        // NOTE: default assignment first so every path drives w_match; otherwise a latch is inferred.
        w_match = 1'b0;
        case (w_mode)
            MODE_BYPASS: w_match = 1'b0;
            MODE_ROCE:   w_match = w_roce;
            default:     w_match = w_ack;
        endcase
    end

    // Single-beat packets classify on the spot; longer ones use the first-beat verdict.
    assign w_eff_match = r_sop ? w_match : r_pkt_match;
    assign w_load      = w_last_acc & w_eff_match;

    always_comb begin
        w_gap_nxt = r_gap_cnt;
        if (w_mode == MODE_BYPASS) begin
            w_gap_nxt = '0;
        end else if (w_load) begin
            w_gap_nxt = cfg_gap;
        end else if (r_gap_cnt != '0) begin
            w_gap_nxt = r_gap_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge nclk) begin
        // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
        if (!nresetn) begin
            r_sop         <= 1'b1;
            r_pkt_match   <= 1'b0;
            r_gap_cnt     <= '0;
            r_gap_active  <= 1'b0;
            r_match_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_accept) begin
                r_sop <= input_stream.tlast;
            end
            if (w_accept && r_sop && !input_stream.tlast) begin
                r_pkt_match <= w_match;
            end else if (w_last_acc) begin
                r_pkt_match <= 1'b0;
            end

            r_gap_cnt    <= w_gap_nxt;
            r_gap_active <= (w_gap_nxt != '0);

            if (stats_clear) begin
                r_match_count <= '0;
            end else if (w_load) begin
                r_match_count <= r_match_count + 32'd1;
            end

            if (stats_clear) begin
                r_stall_count <= '0;
            end else if (input_stream.tvalid && w_gate && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign gap_active  = r_gap_active;
    assign match_count = r_match_count;
    assign stall_count = r_stall_count;
endmodule

// File: tb/tb_rdma_ack_pacer.sv
// Scoreboard bench for rdma_ack_pacer: beats are queued when driven and compared when they
// leave the pacer; accept cycles are logged to check gap spacing.
module tb_rdma_ack_pacer;
    localparam int DW = 256;

    logic        nclk = 1'b0;
    logic        nresetn;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_gap;
    logic        stats_clear;
    logic        gap_active;
    logic [31:0] match_count;
    logic [31:0] stall_count;

    AXI4S #(.DATA_W(DW)) in_if ();
    AXI4S #(.DATA_W(DW)) out_if ();

    rdma_ack_pacer dut (
        .nclk          (nclk),
        .nresetn       (nresetn),
        .input_stream  (in_if),
        .output_stream (out_if),
        .cfg_mode      (cfg_mode),
        .cfg_gap       (cfg_gap),
        .stats_clear   (stats_clear),
        .gap_active    (gap_active),
        .match_count   (match_count),
        .stall_count   (stall_count)
    );

    always #5 nclk = ~nclk;

    typedef struct {
        logic [63:0] lo;
        logic [31:0] keep;
        logic        last;
    } beat_t;

    beat_t sb_q[$];
    int    acc_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    beat_idx = 0;
    int    gap_n;

    always @(posedge nclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: every beat leaving the pacer must match the head of the scoreboard.
    always @(negedge nclk) begin
        beat_t e;
        if (nresetn === 1'b1 && out_if.tvalid === 1'b1 && out_if.tready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_data", out_if.tdata[63:0], e.lo);
                check("sb_keep", {32'd0, out_if.tkeep}, {32'd0, e.keep});
                check("sb_last", {63'd0, out_if.tlast}, {63'd0, e.last});
            end
            acc_q.push_back(cyc);
        end
    end

    function automatic logic [DW-1:0] mk(input logic roce, input logic [7:0] opc, input int idx);
        logic [DW-1:0] d;
        d          = '0;
        d[15:0]    = roce ? 16'h0245 : 16'h0999;
        d[231:224] = opc;
        d[63:32]   = idx;
        return d;
    endfunction

    function automatic int sp(input int i);
        if (i < 1 || i >= acc_q.size()) return -1;
        return acc_q[i] - acc_q[i-1];
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the beat is accepted.
    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        beat_t e;
        bit    ok;
        in_if.tdata  = d;
        in_if.tkeep  = '1;
        in_if.tlast  = last;
        in_if.tvalid = 1'b1;
        e.lo   = d[63:0];
        e.keep = '1;
        e.last = last;
        sb_q.push_back(e);
        ok = 1'b0;
        for (int w = 0; w < 2000 && !ok; w++) begin
            @(negedge nclk);
            ok = (in_if.tready === 1'b1);
            @(posedge nclk);
            #1;
        end
        if (!ok) check("beat_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_pkt(input logic roce, input logic [7:0] opc, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            if (b == 0) send_beat(mk(roce, opc, beat_idx), (b == nbeats - 1));
            else        send_beat(mk(1'b0, 8'h00, beat_idx), (b == nbeats - 1));
            beat_idx++;
        end
    endtask

    task automatic idle();
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
    endtask

    // Counts consecutive cycles with gap_active high, starting with the current cycle.
    task automatic measure_gap(output int n);
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 1000) begin
            @(negedge nclk);
            if (gap_active === 1'b1) n++;
            else done = 1'b1;
            @(posedge nclk);
            #1;
        end
    endtask

    task automatic clear_stats();
        stats_clear = 1'b1;
        @(posedge nclk);
        #1;
        stats_clear = 1'b0;
    endtask

    initial begin
        nresetn      = 1'b0;
        cfg_mode     = 2'b01;
        cfg_gap      = 16'd85;
        stats_clear  = 1'b0;
        in_if.tvalid = 1'b0;
        in_if.tdata  = '0;
        in_if.tkeep  = '0;
        in_if.tlast  = 1'b0;
        out_if.tready = 1'b1;

        // Reset values and handshake passthrough.
        repeat (2) @(posedge nclk);
        #1;
        in_if.tvalid = 1'b1;
        @(negedge nclk);
        check("rst_out_tvalid", {63'd0, out_if.tvalid}, 64'd1);
        check("rst_in_tready", {63'd0, in_if.tready}, 64'd1);
        @(posedge nclk);
        #1;
        in_if.tvalid = 1'b0;
        nresetn = 1'b1;
        @(negedge nclk);
        check("rst_gap_active", {63'd0, gap_active}, 64'd0);
        check("rst_match_count", {32'd0, match_count}, 64'd0);
        check("rst_stall_count", {32'd0, stall_count}, 64'd0);
        check("rst_out_tvalid_low", {63'd0, out_if.tvalid}, 64'd0);
        out_if.tready = 1'b0;
        #1;
        check("tready_follows_low", {63'd0, in_if.tready}, 64'd0);
        out_if.tready = 1'b1;
        @(posedge nclk);
        #1;

        // A: mode 01, G=85, two back-to-back single-beat ACKs.
        acc_q.delete();
        send_pkt(1'b1, 8'h11, 1);
        send_pkt(1'b1, 8'h11, 1);
        idle();
        check("A_ack_spacing", 64'(sp(1)), 64'd86);
        check("A_gap_active_on", {63'd0, gap_active}, 64'd1);
        measure_gap(gap_n);
        check("A_gap_len", 64'(gap_n), 64'd85);
        check("A_stall_count", {32'd0, stall_count}, 64'd85);
        check("A_match_count", {32'd0, match_count}, 64'd2);

        // B: mode 01, G=85, 4-beat RoCE non-ACK, ACK, 3-beat data.
        clear_stats();
        check("B_clear_match", {32'd0, match_count}, 64'd0);
        check("B_clear_stall", {32'd0, stall_count}, 64'd0);
        acc_q.delete();
        send_pkt(1'b1, 8'h04, 4);
        send_pkt(1'b1, 8'h11, 1);
        send_pkt(1'b0, 8'h00, 3);
        idle();
        check("B_roce_inner", 64'(sp(2)), 64'd1);
        check("B_no_gap_after_roce", 64'(sp(4)), 64'd1);
        check("B_gap_after_ack", 64'(sp(5)), 64'd86);
        check("B_data_beat1", 64'(sp(6)), 64'd1);
        check("B_data_beat2", 64'(sp(7)), 64'd1);
        check("B_match_count", {32'd0, match_count}, 64'd1);
        check("B_stall_count", {32'd0, stall_count}, 64'd85);
        check("B_gap_idle", {63'd0, gap_active}, 64'd0);

        // C: mode 10, G=10, two 3-beat RoCE packets (header on first beat only).
        cfg_mode = 2'b10;
        cfg_gap  = 16'd10;
        clear_stats();
        acc_q.delete();
        send_pkt(1'b1, 8'h04, 3);
        send_pkt(1'b1, 8'h04, 3);
        idle();
        check("C_inner1", 64'(sp(1)), 64'd1);
        check("C_inner2", 64'(sp(2)), 64'd1);
        check("C_gap", 64'(sp(3)), 64'd11);
        check("C_inner3", 64'(sp(4)), 64'd1);
        check("C_inner4", 64'(sp(5)), 64'd1);
        measure_gap(gap_n);
        check("C_gap_len", 64'(gap_n), 64'd10);
        check("C_match_count", {32'd0, match_count}, 64'd2);
        check("C_stall_count", {32'd0, stall_count}, 64'd10);

        // D: mode 01, G=85; switch to bypass when gap_cnt reaches 40 with an ACK waiting.
        cfg_mode = 2'b01;
        cfg_gap  = 16'd85;
        clear_stats();
        acc_q.delete();
        send_pkt(1'b1, 8'h11, 1);
        fork
            send_pkt(1'b1, 8'h11, 1);
            begin
                repeat (45) @(posedge nclk);
                #1;
                check("D_gap_running", {63'd0, gap_active}, 64'd1);
                cfg_mode = 2'b00;
            end
        join
        check("D_bypass_release", 64'(sp(1)), 64'd47);
        check("D_gap_active_off", {63'd0, gap_active}, 64'd0);
        check("D_stall_count", {32'd0, stall_count}, 64'd46);
        send_pkt(1'b1, 8'h11, 1);
        send_pkt(1'b1, 8'h11, 1);
        idle();
        check("D_bypass_b2b1", 64'(sp(2)), 64'd1);
        check("D_bypass_b2b2", 64'(sp(3)), 64'd1);
        check("D_stall_frozen", {32'd0, stall_count}, 64'd46);
        check("D_match_count", {32'd0, match_count}, 64'd1);

        // E: cfg_gap 85 -> 5 during a running gap.
        cfg_mode = 2'b01;
        cfg_gap  = 16'd85;
        clear_stats();
        acc_q.delete();
        send_pkt(1'b1, 8'h11, 1);
        fork
            send_pkt(1'b1, 8'h11, 1);
            begin
                repeat (20) @(posedge nclk);
                #1;
                cfg_gap = 16'd5;
            end
        join
        send_pkt(1'b1, 8'h11, 1);
        idle();
        check("E_old_gap", 64'(sp(1)), 64'd86);
        check("E_new_gap", 64'(sp(2)), 64'd6);
        measure_gap(gap_n);
        check("E_gap_len", 64'(gap_n), 64'd5);
        check("E_stall_count", {32'd0, stall_count}, 64'd90);
        check("E_match_count", {32'd0, match_count}, 64'd3);

        // F: stats_clear wins over a same-cycle match; G=0 runs at full rate.
        cfg_gap = 16'd0;
        acc_q.delete();
        stats_clear = 1'b1;
        send_pkt(1'b1, 8'h11, 1);
        stats_clear = 1'b0;
        check("F_clear_priority", {32'd0, match_count}, 64'd0);
        send_pkt(1'b1, 8'h11, 1);
        send_pkt(1'b1, 8'h11, 1);
        send_pkt(1'b1, 8'h11, 1);
        idle();
        check("F_g0_b2b1", 64'(sp(1)), 64'd1);
        check("F_g0_b2b3", 64'(sp(3)), 64'd1);
        check("F_g0_no_gap", {63'd0, gap_active}, 64'd0);
        check("F_match_count", {32'd0, match_count}, 64'd3);
        check("F_stall_count", {32'd0, stall_count}, 64'd0);

        // G: reset mid-packet discards sop/pkt_match state.
        cfg_mode = 2'b10;
        cfg_gap  = 16'd10;
        acc_q.delete();
        send_beat(mk(1'b1, 8'h04, beat_idx), 1'b0);
        beat_idx++;
        idle();
        nresetn = 1'b0;
        repeat (2) @(posedge nclk);
        #1;
        nresetn = 1'b1;
        @(negedge nclk);
        check("G_rst_gap_active", {63'd0, gap_active}, 64'd0);
        check("G_rst_match", {32'd0, match_count}, 64'd0);
        check("G_rst_stall", {32'd0, stall_count}, 64'd0);
        check("G_rst_tready", {63'd0, in_if.tready}, 64'd1);
        @(posedge nclk);
        #1;
        send_pkt(1'b0, 8'h00, 1);
        idle();
        check("G_nonroce_no_gap", {63'd0, gap_active}, 64'd0);
        check("G_nonroce_no_match", {32'd0, match_count}, 64'd0);
        send_pkt(1'b1, 8'h04, 1);
        idle();
        check("G_roce_gap", {63'd0, gap_active}, 64'd1);
        check("G_roce_match", {32'd0, match_count}, 64'd1);
        measure_gap(gap_n);
        check("G_gap_len", 64'(gap_n), 64'd10);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rdma_ack_pacer.md
# rdma_ack_pacer

Packet-aware, runtime-configurable gap enforcer for the RDMA receive path, placed directly after the ingress buffering FIFO. It classifies each packet on its first beat and, after the last beat of a matching packet, holds off the start of the next packet for a programmable number of cycles. Packets already in flight are never stalled mid-packet. Mode select and statistics counters let software tune or bypass pacing without a rebuild.

## Interface
Parameters:
- HDR_MATCH, 16'h0245: value compared against tdata[15:0] on the first beat to identify RoCE traffic.
- OPC_LSB, 224: LSB of the 8-bit opcode field within the first beat.
- ACK_OPC, 8'h11: opcode that identifies an ACK.
- CNT_W, 16: width of the gap counter and cfg_gap.

Ports:
- nclk  in  1  clock.
- nresetn  in  1  reset; nresetn, synchronous, active-low; clock nclk.
- input_stream  AXI4S.s  -  ingress stream from the FIFO (tdata/tkeep/tlast/tvalid/tready).
- output_stream  AXI4S.m  -  paced stream to the RDMA stack.
- cfg_mode  in  2  00 bypass, 01 ACK-only, 10 all RoCE, 11 treated as 01.
- cfg_gap  in  CNT_W  gap length in cycles; 0 disables pacing.
- stats_clear  in  1  synchronous clear of both stats counters.
- gap_active  out  1  high while gap_cnt != 0.
- match_count  out  32  matching packets completed; wraps.
- stall_count  out  32  cycles a packet start was held off; saturates at 0xFFFFFFFF.

## Operation
- sop register, reset 1: on each accepted beat (tvalid & tready), sop <= tlast.
- First-beat match, evaluated only when sop=1:
  - roce = tdata[15:0]==HDR_MATCH.
  - ack = roce & tdata[OPC_LSB+:8]==ACK_OPC.
  - match = ack in mode 01/11, roce in mode 10, 0 in mode 00.
- pkt_match register, reset 0: loaded with match on an accepted first beat that is not the last beat; cleared on an accepted last beat.
- Effective match for the last beat: match if sop=1 (single-beat packet), otherwise pkt_match.
- gap_cnt, reset 0:
  - An accepted last beat with effective match=1 loads cfg_gap. cfg_gap is sampled only at this load.
  - Otherwise gap_cnt decrements while it is nonzero.
  - In mode 00, gap_cnt is forced to 0 every cycle, which overrides the load.
- gate = sop & (gap_cnt != 0).
  - output_stream.tvalid = input_stream.tvalid & !gate.
  - input_stream.tready = output_stream.tready & !gate.
  - tdata, tkeep and tlast pass through unchanged.
- Mid-packet beats (sop=0) are never gated, so a gap never splits a packet.
- match_count increments on each accepted last beat with effective match=1.
- stall_count increments each cycle with input_stream.tvalid & gate, and saturates.
- stats_clear takes priority over increments in the same cycle.
- A mode change is applied on the next first beat; pkt_match of a packet in flight is unaffected. The exception is mode 00, which clears any running gap immediately.
- A cfg_gap change during a running gap has no effect until the next load.

## Timing
- Data path is combinational: zero latency, no buffering.
- Reset values: gap_cnt=0, sop=1, pkt_match=0, gap_active=0, match_count=0, stall_count=0. Both tvalid and tready follow their counterparts immediately after reset.
- Matching last beat accepted at cycle t with cfg_gap=G>0:
  - gap_cnt=G at t+1, counting down to 1 at t+G.
  - The next first beat is accepted no earlier than t+G+1, giving exactly G blocked cycles.
- gap_active is registered (gap_cnt!=0) and is high for cycles t+1..t+G.
- G=0: no gap; back-to-back packets flow at full rate.
- A matching last beat accepted while gap_cnt!=0 is possible only on mid-packet beats, because a gap starts only after a last beat. Such a load restarts the count at cfg_gap.
- Reset asserted mid-packet returns the block to sop=1 and discards pkt_match. The upstream FIFO must be reset together with this block.
- output_stream.tready low while gate=0 is a normal stall; counters and gap_cnt behave as specified regardless.

## Test plan
- Mode 01, G=85: two single-beat ACKs (tdata[15:0]=0245, opcode 0x11) back to back. Second accepted exactly 86 cycles after first; stall_count=85; match_count=2.
- Mode 01, G=85: 4-beat non-ACK RoCE packet, then ACK, then 3-beat data packet. No gap after the RoCE packet; 85-cycle gap after the ACK; all data beats pass without gating; match_count=1.
- Mode 10, G=10: two 3-beat RoCE packets. Gap starts after the tlast beat of each; no bubble between beats inside a packet.
- Mode 00 set at gap_cnt=40 while a packet waits: tvalid passes the very next cycle; gap_active=0; no further stall_count increments.
- cfg_gap changed 85→5 mid-gap: current gap completes at 85; next ACK produces a 5-cycle gap.
- stats_clear asserted on the same cycle as a match increment: match_count=0. stall_count preset to saturation via a long stall stays at 0xFFFFFFFF. Reset mid-packet: sop=1, all outputs at reset values.
